prbs23_gen: RTL and testbench
=============================

Name: prbs23_gen

Overview:
- Parallel PRBS-23 generator. Produces a 17-bit signed pseudo-random word every enabled clock.
- Feeds noise sources in stimulus and test infrastructure. Several instances with different seeds give uncorrelated noise, e.g. common-mode and per-leg differential noise.
- Internally a 23-bit Fibonacci LFSR (x^23 + x^18 + 1), advanced WIDTH steps per clock.

Parameters:
- SEED, 23'h000001, 23-bit initial LFSR state loaded on reset and on init.
- WIDTH, 17, output word width and LFSR steps per enabled clock; legal range 1..23.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  advance enable; synchronous.
- init  input  1  synchronous reload of SEED; priority over en.
- data  output  WIDTH  registered pseudo-random word; signed two's-complement.

Behaviour:
- State s[22:0]. One LFSR step:
  - fb = s[22] ^ s[17]
  - s <= {s[21:0], fb}
- Per enabled clock, WIDTH steps are applied combinationally, unrolled, and the result is registered in one cycle.
- data is the low WIDTH bits of the state register: data = s[WIDTH-1:0].
  - data[WIDTH-1] = oldest of the newly generated bits; data[0] = newest.
- reset low, asynchronous: s <= SEED immediately; data = SEED[WIDTH-1:0]. Held while reset is low.
- After reset deasserts, rising-edge priority:
  - init=1: s <= SEED, regardless of en.
  - else en=1: s <= s advanced WIDTH steps.
  - else: hold.
- Latency: data reflects the new state one clock after the qualifying edge. There is no combinational path from en/init to data.
- Sequence period is 2^23-1 steps for any non-zero SEED. Word-level period is (2^23-1)/gcd(2^23-1, WIDTH); for WIDTH=17 this is 2^23-1 words.
- SEED=0 without the optional feature locks the LFSR at zero (data stays 0). This is legal but useless.
- Reset asserted mid-run overrides everything, including an init pending on the same edge.
- en/init asserted on the same edge as reset deassertion: the edge is evaluated normally, because reset is already released at that edge.
- Output is never X after reset. No internal counters or handshakes.

Optional Feature:
- Macro: PRBS23_LOCKUP_GUARD_EN.
- Defined:
  - If the state about to be loaded (from SEED via reset or init, or from an advance) is all-zero, 23'h000001 is loaded instead.
  - The generator therefore can never lock up, even with SEED=0.
- Undefined:
  - No check; the all-zero state persists as stated above.
  - No extra logic is inferred.

Test Plan:
- SEED=23'h000001, reset low then high, en=0: data=17'h00001 and holds indefinitely.
- SEED=23'h000001, en=1 after reset:
  - cycle 1: s=23'h020000, data=17'h00000.
  - cycle 2: s=23'h010800, data=17'h10800 (negative).
- SEED=23'h7FF801 (testbench-style seed): data=17'h1F801 (-2047) immediately after reset. After 1000 enabled cycles, pulse init=1 with en=1: data returns to 17'h1F801 on the next cycle.
- Async reset mid-run: assert reset between clock edges while en=1. data becomes 17'h1F801 without waiting for an edge and holds until release.
- Full-period check, SEED=23'h000001, en=1 continuously:
  - state first returns to SEED after exactly 2^23-1 cycles;
  - no all-zero state is ever seen;
  - the running mean of signed data is approximately 0 (|mean| < 64).
- SEED=0:
  - with PRBS23_LOCKUP_GUARD_EN: after reset s=23'h000001, and cycle 1 gives data=17'h00000, s=23'h020000;
  - without the macro: data stays 17'h00000 forever.

Source files
------------

// File: rtl/prbs23_gen.sv
// Parallel PRBS-23 (x^23 + x^18 + 1) generator, WIDTH LFSR steps per enabled clock.
// Optional PRBS23_LOCKUP_GUARD_EN replaces any all-zero state load with 23'h000001.
module prbs23_gen #(
  parameter logic [22:0] SEED  = 23'h000001,
  parameter int          WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             init,
  output logic [WIDTH-1:0] data
);

`ifdef PRBS23_LOCKUP_GUARD_EN
  localparam logic [22:0] SEED_LD =
    (SEED == 23'h0) ? 23'h000001 : SEED;
`else
  localparam logic [22:0] SEED_LD = SEED;
`endif

  logic [22:0] s;
  logic [22:0] s_adv;
  logic [22:0] s_nxt;

  // Newest bit enters at s[0], so data[0] is the last generated bit.
  always_comb begin
    s_adv = s;
    for (int i = 0; i < WIDTH; i++) begin
      s_adv = {s_adv[21:0], s_adv[22] ^ s_adv[17]};
    end
`ifdef PRBS23_LOCKUP_GUARD_EN
    if (s_adv == 23'h0) begin
      s_adv = 23'h000001;
    end
`endif
  end

  always_comb begin
    s_nxt = s;
    if (init) begin
      s_nxt = SEED_LD;
    end else if (en) begin
      s_nxt = s_adv;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= SEED_LD;
    end else begin
      s <= s_nxt;
    end
  end

  assign data = s[WIDTH-1:0];

endmodule

// File: tb/tb_prbs23_gen.sv
// Bench for prbs23_gen: directed vectors plus a bit-serial reference LFSR.
// Covers several seeds and widths 1, 17 and 23 on shared controls.
module tb_prbs23_gen;

  localparam logic [22:0] S0 = 23'h000001;
  localparam logic [22:0] S1 = 23'h7FF801;
  localparam logic [22:0] S4 = 23'h000000;

  logic        clk;
  logic        reset;
  logic        en;
  logic        init;
  logic [16:0] d0;
  logic [16:0] d1;
  logic [0:0]  d2;
  logic [22:0] d3;
  logic [16:0] d4;

  int checks;
  int failures;

  logic [22:0] m0, m1, m2, m3, m4;

  prbs23_gen #(.SEED(S0), .WIDTH(17)) u0 (
    .clk(clk), .reset(reset), .en(en), .init(init), .data(d0)
  );
  prbs23_gen #(.SEED(S1), .WIDTH(17)) u1 (
    .clk(clk), .reset(reset), .en(en), .init(init), .data(d1)
  );
  prbs23_gen #(.SEED(S0), .WIDTH(1)) u2 (
    .clk(clk), .reset(reset), .en(en), .init(init), .data(d2)
  );
  prbs23_gen #(.SEED(S0), .WIDTH(23)) u3 (
    .clk(clk), .reset(reset), .en(en), .init(init), .data(d3)
  );
  prbs23_gen #(.SEED(S4), .WIDTH(17)) u4 (
    .clk(clk), .reset(reset), .en(en), .init(init), .data(d4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] grd(input logic [22:0] x);
`ifdef PRBS23_LOCKUP_GUARD_EN
    return (x == 23'h0) ? 23'h000001 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [22:0] adv(
    input logic [22:0] x, input int n
  );
    logic [22:0] t;
    logic fb;
    t = x;
    for (int k = 0; k < n; k++) begin
      fb = t[22] ^ t[17];
      t = t << 1;
      t[0] = fb;
    end
    return grd(t);
  endfunction

  task automatic chk(
    input string tag, input logic [22:0] obs, input logic [22:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic load_models();
    m0 = grd(S0);
    m1 = grd(S1);
    m2 = grd(S0);
    m3 = grd(S0);
    m4 = grd(S4);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".u0"}, {6'b0, d0}, {6'b0, m0[16:0]});
    chk({tag, ".u1"}, {6'b0, d1}, {6'b0, m1[16:0]});
    chk({tag, ".u2"}, {22'b0, d2}, {22'b0, m2[0]});
    chk({tag, ".u3"}, d3, m3);
    chk({tag, ".u4"}, {6'b0, d4}, {6'b0, m4[16:0]});
  endtask

  // Entered at a negedge; leaves at the following negedge.
  task automatic tick(input logic e, input logic i);
    en = e;
    init = i;
    @(posedge clk);
    if (!reset) begin
      load_models();
    end else if (i) begin
      load_models();
    end else if (e) begin
      m0 = adv(m0, 17);
      m1 = adv(m1, 17);
      m2 = adv(m2, 1);
      m3 = adv(m3, 23);
      m4 = adv(m4, 17);
    end
    @(negedge clk);
  endtask

  logic [16:0] z4;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    en = 1'b0;
    init = 1'b0;
`ifdef PRBS23_LOCKUP_GUARD_EN
    z4 = 17'h00001;
`else
    z4 = 17'h00000;
`endif

    #1 reset = 1'b0;
    #2;
    chk("rst_async_u0", {6'b0, d0}, 23'h000001);
    chk("rst_async_u1", {6'b0, d1}, 23'h01F801);
    chk("rst_async_u3", d3, 23'h000001);
    chk("rst_async_u4", {6'b0, d4}, {6'b0, z4});
    load_models();

    @(negedge clk);
    repeat (3) tick(1'b1, 1'b1);
    chk("rst_hold_u0", {6'b0, d0}, 23'h000001);
    chk("rst_hold_u1", {6'b0, d1}, 23'h01F801);

    reset = 1'b1;
    repeat (4) begin
      tick(1'b0, 1'b0);
      chk("idle_u0", {6'b0, d0}, 23'h000001);
    end

    tick(1'b1, 1'b0);
    chk("step1_u0", {6'b0, d0}, 23'h000000);
    chk("step1_u3", d3, 23'h000021);
    chk("step1_u4", {6'b0, d4}, 23'h000000);
    check_all("step1");
    tick(1'b1, 1'b0);
    chk("step2_u0", {6'b0, d0}, 23'h010800);
`ifdef PRBS23_LOCKUP_GUARD_EN
    chk("step2_u4", {6'b0, d4}, 23'h010800);
`else
    chk("step2_u4", {6'b0, d4}, 23'h000000);
`endif
    check_all("step2");

    repeat (2) begin
      tick(1'b0, 1'b0);
      chk("hold_u0", {6'b0, d0}, 23'h010800);
    end

    for (int c = 0; c < 1000; c++) begin
      tick(1'b1, 1'b0);
      check_all("run");
    end

    tick(1'b1, 1'b1);
    chk("init_u1", {6'b0, d1}, 23'h01F801);
    chk("init_u0", {6'b0, d0}, 23'h000001);
    check_all("init");

    repeat (5) tick(1'b1, 1'b0);
    check_all("rerun");

    @(posedge clk);
    #2;
    init = 1'b1;
    reset = 1'b0;
    #1;
    chk("mid_rst_u1", {6'b0, d1}, 23'h01F801);
    chk("mid_rst_u0", {6'b0, d0}, 23'h000001);
    load_models();
    @(negedge clk);
    repeat (2) tick(1'b1, 1'b1);
    chk("mid_hold_u1", {6'b0, d1}, 23'h01F801);
    check_all("mid_hold");

    reset = 1'b1;
    tick(1'b1, 1'b0);
    chk("release_u0", {6'b0, d0}, 23'h000000);
    check_all("release");
    repeat (20) begin
      tick(1'b1, 1'b0);
      check_all("tail");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
